// File: rtl/blake2_pkg.sv
// rtl/blake2_pkg.sv - shared constants and FSM encoding for the blake2 message packer
package blake2_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int IDX_W       = 7;
  localparam int LL_W        = 64;
  localparam int BB_B2B      = 128;
  localparam int BB_B2S      = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAD  = 2'd2,
    S_BUSY = 2'd3
  } state_t;

endpackage

// File: rtl/blake2_msg_packer.sv
// rtl/blake2_msg_packer.sv - slices a byte stream into zero-padded blocks for the blake2 core
module blake2_msg_packer
  import blake2_pkg::*;
#(
  parameter int BLOCK_BYTES = blake2_pkg::BLOCK_BYTES,
  parameter int IDX_W       = blake2_pkg::IDX_W,
  parameter int LL_W        = blake2_pkg::LL_W,
  parameter int BB          = BB_B2B
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  input  logic             s_empty_i,
  output logic             s_ready_o,
  input  logic             h_ready_i,
  output logic             data_v_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       data_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic [BB-1:0]    ll_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [LL_W-1:0]  LL_ONE   = LL_W'(1);

  state_t           state;
  logic [IDX_W-1:0] nidx;
  logic [LL_W-1:0]  ll;
  logic             first_blk;
  logic             last_blk;
  logic             seen_low;
  logic             accept;

  assign s_ready_o = h_ready_i & ((state == S_IDLE) | (state == S_DATA));
  assign accept    = s_valid_i & s_ready_o;
  assign ll_o      = BB'(ll);

  // nidx is the index the next emitted byte will carry, not the last one sent
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= S_IDLE;
      nidx          <= '0;
      ll            <= '0;
      first_blk     <= 1'b0;
      last_blk      <= 1'b0;
      seen_low      <= 1'b0;
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      data_o        <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
    end else begin
      data_v_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            first_blk     <= 1'b1;
            block_first_o <= 1'b1;
            if (s_empty_i) begin
              ll           <= '0;
              block_last_o <= 1'b1;
              last_blk     <= 1'b1;
              nidx         <= '0;
              state        <= S_PAD;
            end else begin
              data_v_o     <= 1'b1;
              data_idx_o   <= '0;
              data_o       <= s_data_i;
              block_last_o <= s_last_i;
              last_blk     <= s_last_i;
              ll           <= LL_ONE;
              nidx         <= IDX_ONE;
              if (BLOCK_BYTES == 1) begin
                state    <= S_BUSY;
                seen_low <= 1'b0;
              end else begin
                state <= s_last_i ? S_PAD : S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            data_v_o      <= 1'b1;
            data_idx_o    <= nidx;
            data_o        <= s_data_i;
            block_first_o <= first_blk;
            block_last_o  <= s_last_i;
            last_blk      <= s_last_i;
            ll            <= ll + LL_ONE;
            nidx          <= nidx + IDX_ONE;
            if (nidx == LAST_IDX) begin
              state    <= S_BUSY;
              seen_low <= 1'b0;
            end else if (s_last_i) begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (h_ready_i) begin
            data_v_o      <= 1'b1;
            data_idx_o    <= nidx;
            data_o        <= '0;
            block_first_o <= first_blk;
            block_last_o  <= 1'b1;
            nidx          <= nidx + IDX_ONE;
            if (nidx == LAST_IDX) begin
              state    <= S_BUSY;
              seen_low <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          // the core lowers ready one cycle after the last index, so wait for low then high
          if (!h_ready_i) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            seen_low <= 1'b0;
            nidx     <= '0;
            if (last_blk) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DATA;
              first_blk <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_msg_packer.sv
// tb/tb_blake2_msg_packer.sv - self-checking bench for blake2_msg_packer
module tb_blake2_msg_packer;

  typedef struct {
    logic [6:0]  idx;
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic [63:0] ll;
  } emit_t;

  typedef struct {
    int len;
    bit abc;
    bit empty;
    int gap;
    int hold_low;
    int stall_idx;
    int stall_len;
    int exp_ll;
    int exp_pulses;
  } vec_t;

  logic         clk = 1'b0;
  logic         nreset;
  logic         s_valid_i, s_last_i, s_empty_i, h_ready_i;
  logic [7:0]   s_data_i;
  logic         s_ready_o, data_v_o, block_first_o, block_last_o;
  logic [6:0]   data_idx_o;
  logic [7:0]   data_o;
  logic [127:0] ll_o;

  int total  = 0;
  int passed = 0;

  blake2_msg_packer dut (
    .clk(clk), .nreset(nreset),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_empty_i(s_empty_i),
    .s_ready_o(s_ready_o), .h_ready_i(h_ready_i),
    .data_v_o(data_v_o), .data_idx_o(data_idx_o), .data_o(data_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o), .ll_o(ll_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_msg(input vec_t v, input int reset_at);
    logic [7:0] msg[$];
    emit_t      exp_q[$];
    emit_t      e;
    int         n, nb, sent, target, pulses, low_cnt;
    bit         stalled, done, aborted, prev_h;

    n = v.len;
    for (int i = 0; i < n; i++) msg.push_back(v.abc ? 8'(8'h61 + i) : 8'($urandom));
    nb = (n == 0) ? 1 : (n + 63) / 64;
    for (int p = 0; p < nb * 64; p++) begin
      e.idx   = 7'(p % 64);
      e.data  = (p < n) ? msg[p] : 8'h00;
      e.first = (p < 64);
      e.last  = (n == 0) || (p >= n - 1);
      e.ll    = (p < n) ? 64'(p + 1) : 64'(n);
      exp_q.push_back(e);
    end

    target  = v.empty ? 1 : n;
    sent    = 0;
    pulses  = 0;
    low_cnt = 0;
    stalled = 0;
    done    = 0;
    aborted = 0;
    prev_h  = h_ready_i;

    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (data_v_o) begin
        pulses++;
        chk("no_emit_while_core_busy", 192'(prev_h), 192'(1));
        if (exp_q.size() == 0) begin
          chk("extra_emission", 192'(1), 192'(0));
        end else begin
          e = exp_q.pop_front();
          chk("emit{idx,data,first,last,ll}",
              192'({data_idx_o, data_o, block_first_o, block_last_o, ll_o}),
              192'({e.idx, e.data, e.first, e.last, 64'd0, e.ll}));
        end
        if (reset_at >= 0 && int'(data_idx_o) == reset_at) begin
          h_ready_i = 1'b0;
          s_valid_i = 1'b0;
          nreset    = 1'b0;
          #1;
          chk("async_reset_outputs",
              192'({data_v_o, data_idx_o, data_o, block_first_o, block_last_o, ll_o, s_ready_o}),
              192'(0));
          aborted = 1;
          done    = 1;
        end
        if (data_idx_o == 7'd63) low_cnt = v.hold_low;
        if (v.stall_idx >= 0 && !stalled && int'(data_idx_o) == v.stall_idx) begin
          low_cnt = v.stall_len;
          stalled = 1;
        end
      end
      if (!aborted) begin
        h_ready_i = (low_cnt == 0);
        if (low_cnt > 0) low_cnt--;
        prev_h = h_ready_i;
        if (v.empty) begin
          s_valid_i = (sent == 0);
          s_empty_i = 1'b1;
          s_last_i  = 1'b1;
          s_data_i  = 8'($urandom);
        end else if (sent < n) begin
          s_valid_i = ($urandom_range(99) >= v.gap);
          s_data_i  = msg[sent];
          s_last_i  = (sent == n - 1);
          s_empty_i = 1'b0;
        end else begin
          s_valid_i = 1'b0;
          s_last_i  = 1'b0;
          s_empty_i = 1'b0;
        end
        #1;
        if (!h_ready_i) chk("s_ready_low_while_core_busy", 192'(s_ready_o), 192'(0));
        if (s_valid_i && s_ready_o) sent++;
        if (sent >= target && exp_q.size() == 0 && h_ready_i && s_ready_o) done = 1;
      end
    end

    s_valid_i = 1'b0;
    s_empty_i = 1'b0;
    s_last_i  = 1'b0;
    if (aborted) begin
      @(negedge clk);
      nreset    = 1'b1;
      h_ready_i = 1'b1;
    end else begin
      chk("msg_complete_in_budget", 192'(done), 192'(1));
      if (!done) begin
        nreset = 1'b0;
        @(negedge clk);
        nreset    = 1'b1;
        h_ready_i = 1'b1;
      end else begin
        chk("pulse_count", 192'(pulses), 192'(v.exp_pulses));
        chk("ll_at_end", 192'(ll_o), 192'(v.exp_ll));
        repeat (3) @(negedge clk);
        chk("idle_no_emit_ll_held", 192'({data_v_o, ll_o}), 192'({1'b0, 128'(v.exp_ll)}));
      end
    end
  endtask

  vec_t vecs[9];
  vec_t abc_v;

  initial begin
    //          len abc empty gap hold stall slen  ll  pulses
    vecs[0] = '{  3, 1, 0,   0,  1,  -1,  0,    3,  64};
    vecs[1] = '{ 64, 0, 0,   0,  2,  -1,  0,   64,  64};
    vecs[2] = '{ 65, 0, 0,   0, 97,  -1,  0,   65, 128};
    vecs[3] = '{  0, 0, 1,   0,  1,  -1,  0,    0,  64};
    vecs[4] = '{100, 0, 0,  30,  3,  20,  5,  100, 128};
    vecs[5] = '{128, 0, 0,  20,  1,  -1,  0,  128, 128};
    vecs[6] = '{  1, 0, 0,   0,  1,  30,  3,    1,  64};
    vecs[7] = '{ 63, 0, 0,  50,  2,  -1,  0,   63,  64};
    vecs[8] = '{130, 0, 0,  10,  4,  50,  2,  130, 192};
    abc_v   = vecs[0];

    nreset    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
    s_empty_i = 1'b0;
    h_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        192'({data_v_o, data_idx_o, data_o, block_first_o, block_last_o, ll_o, s_ready_o}),
        192'(0));
    nreset    = 1'b1;
    h_ready_i = 1'b1;
    #1;
    chk("idle_ready_after_reset", 192'(s_ready_o), 192'(1));

    for (int i = 0; i < 9; i++) run_msg(vecs[i], -1);

    run_msg(abc_v, 40);
    @(negedge clk);
    #1;
    chk("idle_ready_after_abort", 192'({s_ready_o, ll_o}), 192'({1'b1, 128'd0}));
    run_msg(abc_v, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
